mux4_rr_arbiter: RTL and testbench

//  Shares one 4-input data mux among four valid/ready requesters.
//  - Grants are round-robin; a granted requester keeps the mux for a burst of up to BURST_LEN beats.
//  - Winner's data is registered into a single output slot with a valid/ready handshake.
//  - Drives the mux select (sel) and sequences grant, burst and release.

---
 rtl/mux4_rr_arbiter_pkg.sv | 28 ++
 rtl/mux4_rr_arbiter_pick4.sv | 14 +
 rtl/mux4_rr_arbiter.sv | 113 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and the round-robin scan used by the 4-requester mux arbiter.
package mux4_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int N_REQ = 4;

  // Winner is the first set bit scanning last+1, last+2, ... (mod 4).
  function automatic logic [1:0] rr_next(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick4.sv
// Combinational round-robin picker: lowest-priority slot is the last winner.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       any
);

  assign gnt = rr_next(req, last);
  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter sharing one 4:1 data mux, with a single registered
// valid/ready output slot.
//
//   state | meaning
//   IDLE  | no grant held; picks the next requester (costs one cycle)
//   GRANT | sel owns the mux for up to BURST_LEN beats or until it withdraws
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        sel,
  output logic              busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  arb_state_t        state;
  logic [1:0]        last;
  logic [CW-1:0]     beat_cnt;
  logic [1:0]        pick;
  logic              pick_any;
  logic [DATA_W-1:0] d_sel;
  logic              in_beat;

  rr_pick4 u_pick (
    .req  (in_valid),
    .last (last),
    .gnt  (pick),
    .any  (pick_any)
  );

  always_comb begin
    d_sel = d0;
    case (sel)
      2'd0: d_sel = d0;
      2'd1: d_sel = d1;
      2'd2: d_sel = d2;
      2'd3: d_sel = d3;
      default: d_sel = d0;
    endcase
  end

  always_comb begin
    in_ready = 4'b0000;
    if (state == GRANT && (!out_valid || out_ready))
      in_ready[sel] = 1'b1;
  end

  assign in_beat = in_valid[sel] & in_ready[sel];
  assign busy    = (state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      last     <= 2'd3;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            sel      <= pick;
            state    <= GRANT;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (in_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              last     <= sel;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end else if (!in_valid[sel]) begin
            last  <= sel;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slot reloads on an in beat even when it is being drained, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_beat) begin
      out_valid <= 1'b1;
      out_data  <= d_sel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: BURST_LEN=4 instance plus a BURST_LEN=1 instance.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_valid1;
  logic [3:0] d0, d1, d2, d3;
  logic       out_ready;

  logic [3:0] in_ready,  in_ready1;
  logic       out_valid, out_valid1;
  logic [3:0] out_data,  out_data1;
  logic [1:0] sel,       sel1;
  logic       busy,      busy1;

  int tests;
  int fails;

  mux4_rr_arbiter #(.DATA_W(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sel(sel), .busy(busy)
  );

  mux4_rr_arbiter #(.DATA_W(4), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ready(out_ready), .sel(sel1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b0000; in_valid1 = 4'b0000; out_ready = 1'b0;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    #2;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || sel !== 2'd0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_values: ov=%b od=%h sel=%0d busy=%b ir=%b, want 0 0 0 0 0000",
               out_valid, out_data, sel, busy, in_ready);
    end
    step();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000 || busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_cycle%0d: ov=%b ir=%b busy=%b, want 0 0000 0", i, out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_single_stream();
    in_valid = 4'b0100; d2 = 4'hA; out_ready = 1'b1;
    step();
    tests++;
    if (sel !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 4'b0100) begin
      fails++;
      $display("FAIL stream_grant: sel=%0d busy=%b ov=%b ir=%b, want 2 1 0 0100", sel, busy, out_valid, in_ready);
    end
    for (int b = 0; b < 4; b++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'hA || busy !== (b < 3)) begin
        fails++;
        $display("FAIL stream_beat%0d: ov=%b od=%h busy=%b, want 1 a %b", b, out_valid, out_data, busy, (b < 3));
      end
    end
    step();
    tests++;
    if (sel !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_regrant: sel=%0d busy=%b ov=%b, want 2 1 0", sel, busy, out_valid);
    end
    in_valid = 4'b0000;
    step();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_withdraw: busy=%b ov=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_rotate_burst1();
    d0 = 4'h0; d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; out_ready = 1'b1;
    in_valid1 = 4'b1111;
    step();
    tests++;
    if (sel1 !== 2'd0 || busy1 !== 1'b1) begin
      fails++;
      $display("FAIL rot_first_grant: sel=%0d busy=%b, want 0 1", sel1, busy1);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (out_valid1 !== 1'b1 || out_data1 !== 4'(k % 4)) begin
        fails++;
        $display("FAIL rot_word%0d: ov=%b od=%h, want 1 %h", k, out_valid1, out_data1, 4'(k % 4));
      end
      if (k < 4) begin
        step();
        tests++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b1) begin
          fails++;
          $display("FAIL rot_bubble%0d: ov=%b busy=%b, want 0 1", k, out_valid1, busy1);
        end
      end
    end
    in_valid1 = 4'b0000;
    step();
    step();
  endtask

  task automatic test_stall();
    in_valid = 4'b0010; d1 = 4'h5; out_ready = 1'b1;
    step();
    tests++;
    if (sel !== 2'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stall_grant: sel=%0d busy=%b, want 1 1", sel, busy);
    end
    step();
    out_ready = 1'b0; d1 = 4'h6;
    #1;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'h5 || in_ready !== 4'b0000 || dut.beat_cnt !== 1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold%0d: ov=%b od=%h ir=%b cnt=%0d busy=%b, want 1 5 0000 1 1",
                 c, out_valid, out_data, in_ready, dut.beat_cnt, busy);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0010) begin
      fails++;
      $display("FAIL stall_resume_ready: ir=%b, want 0010", in_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'h6 || dut.beat_cnt !== 2) begin
      fails++;
      $display("FAIL stall_resume_word: ov=%b od=%h cnt=%0d, want 1 6 2", out_valid, out_data, dut.beat_cnt);
    end
    in_valid = 4'b0000;
    step();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: busy=%b ov=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_withdraw();
    in_valid = 4'b1000; d3 = 4'hC; out_ready = 1'b1;
    step();
    tests++;
    if (sel !== 2'd3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wd_grant: sel=%0d busy=%b, want 3 1", sel, busy);
    end
    step();
    step();
    tests++;
    if (dut.beat_cnt !== 2 || out_data !== 4'hC) begin
      fails++;
      $display("FAIL wd_two_beats: cnt=%0d od=%h, want 2 c", dut.beat_cnt, out_data);
    end
    in_valid = 4'b0001; d0 = 4'h7;
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wd_idle: busy=%b, want 0", busy);
    end
    step();
    tests++;
    if (sel !== 2'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wd_next_grant: sel=%0d busy=%b, want 0 1", sel, busy);
    end
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    in_valid = 4'b0100; d2 = 4'h9; out_ready = 1'b0;
    step();
    step();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'h9 || sel !== 2'd2) begin
      fails++;
      $display("FAIL rst_pre: ov=%b od=%h sel=%0d, want 1 9 2", out_valid, out_data, sel);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || busy !== 1'b0 || out_data !== 4'h0) begin
      fails++;
      $display("FAIL rst_async: ov=%b ir=%b busy=%b od=%h, want 0 0000 0 0", out_valid, in_ready, busy, out_data);
    end
    in_valid = 4'b0101;
    step();
    #3 rst_n = 1'b1;
    step();
    tests++;
    if (sel !== 2'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_first_grant: sel=%0d busy=%b, want 0 1", sel, busy);
    end
    in_valid = 4'b0000;
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_stream();
    test_rotate_burst1();
    test_stall();
    test_withdraw();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
